// File: rtl/cselsub32_seq_if.sv
// Handshake bundle for the sequential carry-select subtractor: operand
// channel (in_valid/in_ready/a/b) and result channel (out_valid/out_ready/flags).
interface cselsub32_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/cselsub32_seq.sv
// Sequential subtractor: a - b computed as a + ~b + 1, one SLICE-bit
// carry-select slice per clock, with one operation in flight at a time.
module cselsub32_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input logic             clk,
    input logic             rst_n,
    cselsub32_seq_if.slave  bus
);
    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Both carry-in outcomes are formed; the live carry picks one.
    function automatic logic [SLICE:0] csel_slice(input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y,
                                                  input logic             cin);
        logic [SLICE:0] s0;
        logic [SLICE:0] s1;
        s0 = {1'b0, x} + {1'b0, y};
        s1 = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, 1'b1};
        return cin ? s1 : s0;
    endfunction

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             c;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] wd_next;
    logic [SLICE:0]   sel;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;
    logic             zero_r;

    assign accept = (state == ST_IDLE) && bus.in_valid;
    assign last   = (idx == IW'(NS - 1));

    always_comb begin
        sel     = csel_slice(ra[idx*SLICE +: SLICE], rb[idx*SLICE +: SLICE], c);
        wd_next = wd;
        wd_next[idx*SLICE +: SLICE] = sel[SLICE-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            c      <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_RUN;
                        idx   <= '0;
                        c     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    c   <= sel[SLICE];
                    idx <= idx + IW'(1);
                    if (last) begin
                        state  <= ST_DONE;
                        diff_r <= wd_next;
                        bout_r <= ~sel[SLICE];
                        // rb holds ~b, so a and b differing in sign means ra/rb MSBs match
                        ovf_r  <= (ra[WIDTH-1] == rb[WIDTH-1]) &&
                                  (wd_next[WIDTH-1] != ra[WIDTH-1]);
                        zero_r <= (wd_next == '0);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand and working registers need no reset: they are rewritten on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            ra <= bus.a;
            rb <= ~bus.b;
            wd <= '0;
        end else if (state == ST_RUN) begin
            wd <= wd_next;
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;
endmodule

// File: tb/tb_cselsub32_seq.sv
// Scoreboard bench for cselsub32_seq: expected results are queued when an
// operation is issued and popped when the result handshake arrives.
module tb_cselsub32_seq;
    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   checks;
    int   errors;

    cselsub32_seq_if #(.WIDTH(32)) bus ();

    cselsub32_seq #(.WIDTH(32), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.diff = a - b;
        e.bout = (a < b);
        e.ovf  = (a[31] != b[31]) && (e.diff[31] != a[31]);
        e.zero = (e.diff == 32'd0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, wait for the accept edge, then scramble the bus.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit record);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL issue_timeout in_ready=%0b required 1", bus.in_ready);
        end
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        if (record) sb.push_back(model(a, b));
        tick();
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 32'd0 ||
            bus.bout !== 1'b0 || bus.ovf !== 1'b0 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state in_ready=%b out_valid=%b diff=%h bout=%b ovf=%b zero=%b required 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.diff, bus.bout, bus.ovf, bus.zero);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int   cyc;
        exp_t e;
        issue(32'h5, 32'h3, 1'b1);
        wait_out(cyc);
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL basic_latency cycles=%0d required 8", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (bus.diff !== e.diff || bus.bout !== e.bout || bus.ovf !== e.ovf || bus.zero !== e.zero) begin
            errors++;
            $display("FAIL basic_result diff=%h bout=%b ovf=%b zero=%b required %h %b %b %b",
                     bus.diff, bus.bout, bus.ovf, bus.zero, e.diff, e.bout, e.ovf, e.zero);
        end
        checks++;
        if (bus.diff !== 32'h2) begin
            errors++;
            $display("FAIL basic_const diff=%h required 00000002", bus.diff);
        end
        handshake();
    endtask

    task automatic test_borrow_overflow();
        logic [31:0] ta[4] = '{32'h0000_0000, 32'h1000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb_[4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
        logic [31:0] td[4] = '{32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic        tbo[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        tov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int   cyc;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb_[i], 1'b1);
            wait_out(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 8 || bus.diff !== e.diff || bus.bout !== e.bout ||
                bus.ovf !== e.ovf || bus.zero !== e.zero) begin
                errors++;
                $display("FAIL ripple_%0d cyc=%0d diff=%h bout=%b ovf=%b zero=%b required 8 %h %b %b %b",
                         i, cyc, bus.diff, bus.bout, bus.ovf, bus.zero, e.diff, e.bout, e.ovf, e.zero);
            end
            checks++;
            if (bus.diff !== td[i] || bus.bout !== tbo[i] || bus.ovf !== tov[i]) begin
                errors++;
                $display("FAIL table_%0d diff=%h bout=%b ovf=%b required %h %b %b",
                         i, bus.diff, bus.bout, bus.ovf, td[i], tbo[i], tov[i]);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int   cyc;
        exp_t e;
        issue(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        bus.a        = 32'd1;
        bus.b        = 32'd2;
        bus.in_valid = 1'b1;
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL bp_latency cycles=%0d required 8", cyc);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== e.diff ||
                bus.zero !== 1'b1 || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d out_valid=%b in_ready=%b diff=%h zero=%b bout=%b ovf=%b required 1 0 %h 1 0 0",
                         i, bus.out_valid, bus.in_ready, bus.diff, bus.zero, bus.bout, bus.ovf, e.diff);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        handshake();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.zero !== 1'b1 || bus.diff !== 32'd0) begin
            errors++;
            $display("FAIL bp_no_capture out_valid=%b zero=%b diff=%h required 0 1 00000000",
                     bus.out_valid, bus.zero, bus.diff);
        end
    endtask

    task automatic test_reset_inflight();
        int   cyc;
        exp_t e;
        issue(32'h1234_5678, 32'h0000_0042, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 32'd0 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state in_ready=%b out_valid=%b diff=%h zero=%b required 1 0 00000000 0",
                     bus.in_ready, bus.out_valid, bus.diff, bus.zero);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stale out_valid=%b required 0", bus.out_valid);
        end
        issue(32'd100, 32'd58, 1'b1);
        wait_out(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 8 || bus.diff !== e.diff || bus.diff !== 32'd42 || bus.bout !== e.bout ||
            bus.ovf !== e.ovf || bus.zero !== e.zero) begin
            errors++;
            $display("FAIL midrst_followup cyc=%0d diff=%h bout=%b ovf=%b zero=%b required 8 %h %b %b %b",
                     cyc, bus.diff, bus.bout, bus.ovf, bus.zero, e.diff, e.bout, e.ovf, e.zero);
        end
        handshake();
    endtask

    task automatic test_random();
        int          cyc;
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 0) ? ra : $urandom;
            issue(ra, rb, 1'b1);
            wait_out(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 8 || bus.diff !== e.diff || bus.bout !== e.bout ||
                bus.ovf !== e.ovf || bus.zero !== e.zero) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h cyc=%0d diff=%h bout=%b ovf=%b zero=%b required 8 %h %b %b %b",
                         i, ra, rb, cyc, bus.diff, bus.bout, bus.ovf, bus.zero, e.diff, e.bout, e.ovf, e.zero);
            end
            handshake();
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_basic();
        test_reset();
        test_borrow_overflow();
        test_backpressure();
        test_reset_inflight();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover size=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
